// File: rtl/axi_mon_budget_wdt.sv
// Transaction-budget watchdog: accumulates per-burst latency budget, counts it down while
// transactions are outstanding, and flags a sticky timeout. Optional AXI_MON_TIMEOUT_CNT_EN adds an event counter.
module axi_mon_budget_wdt #(
  parameter int MaxTxns      = 8,
  parameter int PrescalerDiv = 2,
  parameter int LenWidth     = 8,
  parameter int CntWidth     = 16,
  parameter int Overhead     = 5,
  localparam int OW = $clog2(MaxTxns + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                enable_i,
  input  logic                push_valid_i,
  output logic                push_ready_o,
  input  logic [LenWidth-1:0] push_len_i,
  input  logic                retire_i,
  input  logic                clear_i,
  output logic [CntWidth-1:0] budget_o,
  output logic [OW-1:0]       outstanding_o,
  output logic                busy_o,
  output logic                timeout_o,
  output logic                irq_o,
  output logic                retire_err_o,
  output logic [7:0]          timeout_cnt_o
);
  localparam int SH = $clog2(PrescalerDiv);
  localparam int PW = (PrescalerDiv > 1) ? $clog2(PrescalerDiv) : 1;
  localparam int WW = CntWidth + LenWidth + 2;

  typedef enum logic [1:0] {IDLE, ACTIVE, TIMEOUT} state_e;

  state_e              state_q;
  logic [CntWidth-1:0] budget_q, budget_d;
  logic [OW-1:0]       out_q, out_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic                irq_q, err_q;
  logic                push_acc, tick;
  logic [WW-1:0]       cost_w, add_w, sub_w;

  assign push_ready_o = (state_q != TIMEOUT) && (out_q < OW'(MaxTxns));
  assign push_acc     = push_valid_i && push_ready_o;
  assign tick         = (state_q == ACTIVE) && enable_i && (presc_q == PW'(PrescalerDiv - 1));

  // Budget arithmetic is done wide so the add cannot wrap before saturation.
  always_comb begin
    cost_w   = ((WW'(push_len_i) + WW'(1)) >> SH) + WW'(Overhead);
    add_w    = WW'(budget_q) + (push_acc ? cost_w : '0);
    sub_w    = (add_w >= WW'(tick)) ? (add_w - WW'(tick)) : '0;
    budget_d = (sub_w > WW'({CntWidth{1'b1}})) ? {CntWidth{1'b1}} : sub_w[CntWidth-1:0];
    out_d    = out_q;
    if (push_acc && !retire_i)      out_d = out_q + OW'(1);
    else if (retire_i && !push_acc) out_d = (out_q != '0) ? out_q - OW'(1) : '0;
    presc_d  = (presc_q == PW'(PrescalerDiv - 1)) ? '0 : presc_q + PW'(1);
  end

`ifdef AXI_MON_TIMEOUT_CNT_EN
  logic [7:0] tcnt_q;
  assign timeout_cnt_o = tcnt_q;
`else
  assign timeout_cnt_o = 8'd0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      budget_q <= '0;
      out_q    <= '0;
      presc_q  <= '0;
      irq_q    <= 1'b0;
      err_q    <= 1'b0;
`ifdef AXI_MON_TIMEOUT_CNT_EN
      tcnt_q   <= 8'd0;
`endif
    end else begin
      irq_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (push_acc && !retire_i) begin
            state_q  <= ACTIVE;
            budget_q <= budget_d;
            out_q    <= out_d;
            presc_q  <= '0;
          end else if (retire_i && !push_acc) begin
            err_q <= 1'b1;
          end
        end
        ACTIVE: begin
          out_q <= out_d;
          if (enable_i) presc_q <= presc_d;
          if (out_d == '0) begin
            state_q  <= IDLE;
            budget_q <= '0;
            presc_q  <= '0;
          end else if (budget_d == '0) begin
            state_q  <= TIMEOUT;
            budget_q <= '0;
            irq_q    <= 1'b1;
`ifdef AXI_MON_TIMEOUT_CNT_EN
            if (tcnt_q != 8'hFF) tcnt_q <= tcnt_q + 8'd1;
`endif
          end else begin
            budget_q <= budget_d;
          end
        end
        TIMEOUT: begin
          if (clear_i) begin
            state_q  <= IDLE;
            budget_q <= '0;
            out_q    <= '0;
            presc_q  <= '0;
          end else if (retire_i && out_q != '0) begin
            out_q <= out_q - OW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign budget_o      = budget_q;
  assign outstanding_o = out_q;
  assign busy_o        = (state_q == ACTIVE);
  assign timeout_o     = (state_q == TIMEOUT);
  assign irq_o         = irq_q;
  assign retire_err_o  = err_q;
endmodule

// File: tb/tb_axi_mon_budget_wdt.sv
// Table-driven, scoreboarded bench for axi_mon_budget_wdt (default build and with AXI_MON_TIMEOUT_CNT_EN).
module tb_axi_mon_budget_wdt;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        en, push, ret, clr, rdy;
  logic [7:0]  len;
  logic [15:0] budget;
  logic [3:0]  outs;
  logic        busy, to, irq, err;
  logic [7:0]  tcnt;

  logic        s_en, s_push, s_ret, s_clr, s_rdy;
  logic [7:0]  s_len;
  logic [3:0]  s_budget;
  logic [3:0]  s_outs;
  logic        s_busy, s_to, s_irq, s_err;
  logic [7:0]  s_tcnt;

  axi_mon_budget_wdt u_dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .push_valid_i(push), .push_ready_o(rdy),
    .push_len_i(len), .retire_i(ret), .clear_i(clr), .budget_o(budget), .outstanding_o(outs),
    .busy_o(busy), .timeout_o(to), .irq_o(irq), .retire_err_o(err), .timeout_cnt_o(tcnt));

  axi_mon_budget_wdt #(.CntWidth(4)) u_small (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(s_en), .push_valid_i(s_push), .push_ready_o(s_rdy),
    .push_len_i(s_len), .retire_i(s_ret), .clear_i(s_clr), .budget_o(s_budget), .outstanding_o(s_outs),
    .busy_o(s_busy), .timeout_o(s_to), .irq_o(s_irq), .retire_err_o(s_err), .timeout_cnt_o(s_tcnt));

`ifdef AXI_MON_TIMEOUT_CNT_EN
  localparam int EXP_TC = 1;
`else
  localparam int EXP_TC = 0;
`endif

  typedef struct {
    int push; int len; int ret; int en; int clr;
    int b; int o; int busy; int to; int irq; int err; int rdy;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input int p, input int l, input int r, input int e, input int c,
                     input int b, input int o, input int bs, input int t, input int iq,
                     input int er, input int rd);
    vec_t v;
    v.push = p; v.len = l; v.ret = r; v.en = e; v.clr = c;
    v.b = b; v.o = o; v.busy = bs; v.to = t; v.irq = iq; v.err = er; v.rdy = rd;
    tbl.push_back(v);
  endtask

  task automatic run(input string tag);
    vec_t e;
    for (int i = 0; i < tbl.size(); i++) begin
      push = tbl[i].push[0]; len = tbl[i].len[7:0]; ret = tbl[i].ret[0];
      en = tbl[i].en[0];     clr = tbl[i].clr[0];
      sb.push_back(tbl[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      chk($sformatf("%s[%0d].budget", tag, i), int'(budget), e.b);
      chk($sformatf("%s[%0d].outstanding", tag, i), int'(outs), e.o);
      chk($sformatf("%s[%0d].busy", tag, i), int'(busy), e.busy);
      chk($sformatf("%s[%0d].timeout", tag, i), int'(to), e.to);
      chk($sformatf("%s[%0d].irq", tag, i), int'(irq), e.irq);
      chk($sformatf("%s[%0d].retire_err", tag, i), int'(err), e.err);
      chk($sformatf("%s[%0d].push_ready", tag, i), int'(rdy), e.rdy);
    end
    push = 0; ret = 0; clr = 0; en = 1;
    tbl.delete();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".budget"}, int'(budget), 0);
    chk({tag, ".outstanding"}, int'(outs), 0);
    chk({tag, ".busy"}, int'(busy), 0);
    chk({tag, ".timeout"}, int'(to), 0);
    chk({tag, ".irq"}, int'(irq), 0);
    chk({tag, ".retire_err"}, int'(err), 0);
    chk({tag, ".tcnt"}, int'(tcnt), 0);
    chk({tag, ".push_ready"}, int'(rdy), 1);
    chk({tag, ".s_budget"}, int'(s_budget), 0);
    chk({tag, ".s_outstanding"}, int'(s_outs), 0);
  endtask

  initial begin
    en = 1; push = 0; ret = 0; clr = 0; len = 0;
    s_en = 1; s_push = 0; s_ret = 0; s_clr = 0; s_len = 0;
    rst_n = 0;
    #23;
    chk_reset("reset");
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // Timeout: cost 7, ticks every second edge, expiry on the 15th edge.
    add(1, 3, 0, 1, 0, 7, 1, 1, 0, 0, 0, 1);
    for (int k = 1; k <= 13; k++) add(0, 0, 0, 1, 0, 7 - k / 2, 1, 1, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 1, 0, 1, 1, 0, 0);
    add(1, 3, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0);   // push refused in TIMEOUT
    add(0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0);   // retire at zero: no error in TIMEOUT
    add(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    run("timeout");
    chk("timeout.tcnt", int'(tcnt), EXP_TC);

    // Retire before expiry returns to IDLE, then retire in IDLE flags an error.
    add(1, 3, 0, 1, 0, 7, 1, 1, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 7, 1, 1, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 6, 1, 1, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 6, 1, 1, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 5, 1, 1, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 5, 1, 1, 0, 0, 0, 1);
    add(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    run("retire");
    chk("retire.tcnt_kept", int'(tcnt), EXP_TC);

    // Fill to MaxTxns, refused 9th push, retire then push+retire.
    add(1, 0, 0, 1, 0,  5, 1, 1, 0, 0, 0, 1);
    add(1, 0, 0, 1, 0, 10, 2, 1, 0, 0, 0, 1);
    add(1, 0, 0, 1, 0, 14, 3, 1, 0, 0, 0, 1);
    add(1, 0, 0, 1, 0, 19, 4, 1, 0, 0, 0, 1);
    add(1, 0, 0, 1, 0, 23, 5, 1, 0, 0, 0, 1);
    add(1, 0, 0, 1, 0, 28, 6, 1, 0, 0, 0, 1);
    add(1, 0, 0, 1, 0, 32, 7, 1, 0, 0, 0, 1);
    add(1, 0, 0, 1, 0, 37, 8, 1, 0, 0, 0, 0);
    add(1, 0, 0, 1, 0, 36, 8, 1, 0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 36, 7, 1, 0, 0, 0, 1);
    add(1, 0, 1, 1, 0, 40, 7, 1, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 40, 7, 1, 0, 0, 0, 1);
    run("full");

    // Asynchronous reset mid-count, checked before the next clock edge.
    #2 rst_n = 0;
    #1 chk_reset("async_rst");
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // enable_i low freezes budget and prescaler.
    add(1, 3, 0, 1, 0, 7, 1, 1, 0, 0, 0, 1);
    for (int k = 0; k < 10; k++) add(0, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 7, 1, 1, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 6, 1, 1, 0, 0, 0, 1);
    run("enable");

    // Narrow counter saturates at 15.
    s_push = 1; s_len = 8'd255;
    repeat (4) @(posedge clk);
    #1;
    chk("sat.budget", int'(s_budget), 15);
    chk("sat.outstanding", int'(s_outs), 4);
    chk("sat.busy", int'(s_busy), 1);
    chk("sat.timeout", int'(s_to), 0);
    s_push = 0;
    @(posedge clk); #1;
    chk("sat.decrement", int'(s_budget), 14);
    chk("sat.tcnt", int'(s_tcnt), 0);
    chk("sat.ready", int'(s_rdy), 1);
    chk("sat.irq_err", int'(s_irq | s_err), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
